// File: rtl/proc_control_unit.sv
// proc_control_unit: Moore control unit for the TCES 330 processor.
// Fetches 16-bit instructions, owns PC and IR, and drives the register-file,
// ALU and data-memory controls as pure functions of State and IR.
// Ports: Clk, Rst (sync, active-high), IMData (ROM data) in;
//        PCAddr, IR, D_Addr, D_Wr, RF_s, WAddr, Wen, RAAddr, RBAddr,
//        RAen, RBen, ALU_s, Halted, State out.
// Optional feature: define CTRL_JUMP_EN to make opcode 0110 a JUMP.

module proc_control_unit #(
    parameter int PC_WIDTH = 7
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic [15:0]         IMData,
    output logic [PC_WIDTH-1:0] PCAddr,
    output logic [15:0]         IR,
    output logic [7:0]          D_Addr,
    output logic                D_Wr,
    output logic                RF_s,
    output logic [3:0]          WAddr,
    output logic                Wen,
    output logic [3:0]          RAAddr,
    output logic [3:0]          RBAddr,
    output logic                RAen,
    output logic                RBen,
    output logic [2:0]          ALU_s,
    output logic                Halted,
    output logic [3:0]          State
);

    localparam logic [3:0] S_INIT   = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_LOAD_A = 4'd3;
    localparam logic [3:0] S_LOAD_B = 4'd4;
    localparam logic [3:0] S_STORE  = 4'd5;
    localparam logic [3:0] S_ADD    = 4'd6;
    localparam logic [3:0] S_SUB    = 4'd7;
    localparam logic [3:0] S_HALT   = 4'd8;
    localparam logic [3:0] S_NOOP   = 4'd9;
`ifdef CTRL_JUMP_EN
    localparam logic [3:0] S_JUMP   = 4'd10;
    localparam logic [3:0] OP_JUMP  = 4'b0110;
`endif

    localparam logic [3:0] OP_STORE = 4'b0001;
    localparam logic [3:0] OP_LOAD  = 4'b0010;
    localparam logic [3:0] OP_ADD   = 4'b0011;
    localparam logic [3:0] OP_SUB   = 4'b0100;
    localparam logic [3:0] OP_HALT  = 4'b0101;

    localparam logic [2:0] ALU_ZERO = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;

    logic [3:0]          state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [15:0]         ir_q, ir_d;

    // Next-state, PC and IR update
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            S_INIT: state_d = S_FETCH;
            S_FETCH: begin
                state_d = S_DECODE;
                ir_d    = IMData;
                // Wraps naturally modulo 2^PC_WIDTH
                pc_d    = pc_q + 1'b1;
            end
            S_DECODE: begin
                case (ir_q[15:12])
                    OP_STORE: state_d = S_STORE;
                    OP_LOAD:  state_d = S_LOAD_A;
                    OP_ADD:   state_d = S_ADD;
                    OP_SUB:   state_d = S_SUB;
                    OP_HALT:  state_d = S_HALT;
`ifdef CTRL_JUMP_EN
                    OP_JUMP:  state_d = S_JUMP;
`endif
                    default:  state_d = S_NOOP;
                endcase
            end
            S_LOAD_A: state_d = S_LOAD_B;
            S_HALT:   state_d = S_HALT;
`ifdef CTRL_JUMP_EN
            S_JUMP: begin
                state_d = S_FETCH;
                pc_d    = ir_q[PC_WIDTH-1:0];
            end
`endif
            default:  state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= S_INIT;
            pc_q    <= '0;
            ir_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // Moore outputs: functions of state_q and ir_q only
    always_comb begin
        D_Wr   = 1'b0;
        RF_s   = 1'b0;
        Wen    = 1'b0;
        RAen   = 1'b0;
        RBen   = 1'b0;
        ALU_s  = ALU_ZERO;
        Halted = 1'b0;
        case (state_q)
            S_LOAD_A: RF_s = 1'b1;
            S_LOAD_B: begin
                RF_s = 1'b1;
                Wen  = 1'b1;
            end
            S_STORE: begin
                RAen = 1'b1;
                D_Wr = 1'b1;
            end
            S_ADD: begin
                RAen  = 1'b1;
                RBen  = 1'b1;
                ALU_s = ALU_ADD;
                Wen   = 1'b1;
            end
            S_SUB: begin
                RAen  = 1'b1;
                RBen  = 1'b1;
                ALU_s = ALU_SUB;
                Wen   = 1'b1;
            end
            S_HALT:  Halted = 1'b1;
            default: ;
        endcase
    end

    // LOAD takes its memory address from the upper byte pair of the operand
    assign D_Addr = (state_q == S_LOAD_A || state_q == S_LOAD_B)
                  ? ir_q[11:4] : ir_q[7:0];

    assign WAddr  = ir_q[3:0];
    assign RAAddr = ir_q[11:8];
    assign RBAddr = ir_q[7:4];
    assign PCAddr = pc_q;
    assign IR     = ir_q;
    assign State  = state_q;

endmodule

// File: tb/tb_proc_control_unit.sv
// Testbench for proc_control_unit: ROM, register file and data memory
// models around the DUT, table vectors, corner sequences, random programs.

module tb_proc_control_unit;

    localparam int PW = 7;

    logic          Clk = 1'b0;
    logic          Rst = 1'b1;
    logic [15:0]   IMData;
    logic [PW-1:0] PCAddr;
    logic [15:0]   IR;
    logic [7:0]    D_Addr;
    logic          D_Wr, RF_s, Wen, RAen, RBen, Halted;
    logic [3:0]    WAddr, RAAddr, RBAddr, State;
    logic [2:0]    ALU_s;

    proc_control_unit #(.PC_WIDTH(PW)) dut (
        .Clk(Clk), .Rst(Rst), .IMData(IMData), .PCAddr(PCAddr), .IR(IR),
        .D_Addr(D_Addr), .D_Wr(D_Wr), .RF_s(RF_s), .WAddr(WAddr), .Wen(Wen),
        .RAAddr(RAAddr), .RBAddr(RBAddr), .RAen(RAen), .RBen(RBen),
        .ALU_s(ALU_s), .Halted(Halted), .State(State)
    );

    always #5 Clk = ~Clk;

    // Instruction ROM, asynchronous read
    logic [15:0] rom [128];
    assign IMData = rom[PCAddr];

    // Datapath model driven by the DUT control outputs
    logic [15:0] rf [16];
    logic [15:0] dm [256];
    logic [15:0] rf_init [16];
    logic [15:0] dm_init [256];
    logic [15:0] opa, opb, alu;
    int wen_cnt = 0;
    int dwr_cnt = 0;

    always_comb begin
        opa = RAen ? rf[RAAddr] : 16'h0;
        opb = RBen ? rf[RBAddr] : 16'h0;
        case (ALU_s)
            3'b001:  alu = opa + opb;
            3'b010:  alu = opa - opb;
            default: alu = 16'h0;
        endcase
    end

    always @(posedge Clk) begin
        if (Wen) wen_cnt <= wen_cnt + 1;
        if (D_Wr) dwr_cnt <= dwr_cnt + 1;
        if (Rst) begin
            for (int i = 0; i < 16; i++) rf[i] <= rf_init[i];
            for (int j = 0; j < 256; j++) dm[j] <= dm_init[j];
        end else begin
            if (Wen) rf[WAddr] <= RF_s ? dm[D_Addr] : alu;
            if (D_Wr) dm[D_Addr] <= rf[RAAddr];
        end
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic reset_dut();
        Rst = 1'b1;
        step();
        step();
        Rst = 1'b0;
    endtask

    task automatic fill_rom(input logic [15:0] v);
        for (int i = 0; i < 128; i++) rom[i] = v;
    endtask

    // Table of single-instruction vectors, checked in the final execute state
    typedef struct {
        logic [15:0] instr;
        int          cyc;
        logic [3:0]  st;
        logic        wen, raen, rben, dwr, rfs;
        logic [2:0]  alus;
        logic [7:0]  daddr;
        logic [3:0]  waddr, raaddr, rbaddr;
    } vec_t;

    vec_t vt [7];

    // ISA-level reference model
    logic [15:0] m_rf [16];
    logic [15:0] m_dm [256];
    int          exp_cyc;

    task automatic model_run(input int n);
        for (int i = 0; i < 16; i++) m_rf[i] = rf_init[i];
        for (int j = 0; j < 256; j++) m_dm[j] = dm_init[j];
        exp_cyc = 1;
        for (int k = 0; k < n; k++) begin
            logic [15:0] ins;
            ins = rom[k];
            case (ins[15:12])
                4'd1: begin
                    m_dm[ins[7:0]] = m_rf[ins[11:8]];
                    exp_cyc += 3;
                end
                4'd2: begin
                    m_rf[ins[3:0]] = m_dm[ins[11:4]];
                    exp_cyc += 4;
                end
                4'd3: begin
                    m_rf[ins[3:0]] = m_rf[ins[11:8]] + m_rf[ins[7:4]];
                    exp_cyc += 3;
                end
                4'd4: begin
                    m_rf[ins[3:0]] = m_rf[ins[11:8]] - m_rf[ins[7:4]];
                    exp_cyc += 3;
                end
                default: exp_cyc += 3;
            endcase
        end
        exp_cyc += 2;
    endtask

    initial begin
        int n;
        int w0, d0;
        logic [15:0] r;

        for (int i = 0; i < 16; i++) rf_init[i] = 16'(i * 16'h0101);
        for (int j = 0; j < 256; j++) dm_init[j] = 16'(j ^ 16'h5A00);

        // Reset and ADD 0x3124
        fill_rom(16'h5000);
        rom[0] = 16'h3124;
        rf_init[1] = 16'h0011;
        rf_init[2] = 16'h0012;
        reset_dut();
        chk("reset state", State, 0);
        chk("reset pc", PCAddr, 0);
        chk("reset ir", IR, 0);
        chk("reset enables", {Wen, RAen, RBen, D_Wr}, 0);
        chk("reset alu/halted", {ALU_s, Halted}, 0);
        step();
        chk("first edge state", State, 1);
        step();
        chk("second edge state", State, 2);
        chk("second edge ir", IR, 16'h3124);
        step();
        chk("add state", State, 6);
        chk("add addrs", {RAAddr, RBAddr, WAddr}, 12'h124);
        chk("add enables", {RAen, RBen, Wen, ALU_s}, 6'b111_001);
        step();
        chk("add then fetch", State, 1);
        chk("add result r4", rf[4], 16'h0023);

        // Table-driven single instructions
        vt[0] = '{16'h3124, 3, 4'd6, 1, 1, 1, 0, 0, 3'd1, 8'h24, 4'h4, 4'h1, 4'h2};
        vt[1] = '{16'h4A5B, 3, 4'd7, 1, 1, 1, 0, 0, 3'd2, 8'h5B, 4'hB, 4'hA, 4'h5};
        vt[2] = '{16'h17C0, 3, 4'd5, 0, 1, 0, 1, 0, 3'd0, 8'hC0, 4'h0, 4'h7, 4'hC};
        vt[3] = '{16'h2A53, 4, 4'd4, 1, 0, 0, 0, 1, 3'd0, 8'hA5, 4'h3, 4'hA, 4'h5};
        vt[4] = '{16'h0000, 3, 4'd9, 0, 0, 0, 0, 0, 3'd0, 8'h00, 4'h0, 4'h0, 4'h0};
        vt[5] = '{16'hF123, 3, 4'd9, 0, 0, 0, 0, 0, 3'd0, 8'h23, 4'h3, 4'h1, 4'h2};
        vt[6] = '{16'h7ABC, 3, 4'd9, 0, 0, 0, 0, 0, 3'd0, 8'hBC, 4'hC, 4'hA, 4'hB};
        fill_rom(16'h5000);
        for (int i = 0; i < 7; i++) rom[i] = vt[i].instr;
        reset_dut();
        step();
        for (int i = 0; i < 7; i++) begin
            chk("tbl fetch state", State, 1);
            chk("tbl fetch pc", PCAddr, i);
            chk("tbl fetch quiet", {Wen, RAen, RBen, D_Wr, RF_s, ALU_s}, 0);
            step();
            chk("tbl decode state", State, 2);
            chk("tbl decode ir", IR, vt[i].instr);
            chk("tbl decode pc", PCAddr, i + 1);
            repeat (vt[i].cyc - 2) step();
            chk("tbl exec state", State, vt[i].st);
            chk("tbl exec enables",
                {Wen, RAen, RBen, D_Wr, RF_s},
                {vt[i].wen, vt[i].raen, vt[i].rben, vt[i].dwr, vt[i].rfs});
            chk("tbl exec alu_s", ALU_s, vt[i].alus);
            chk("tbl exec d_addr", D_Addr, vt[i].daddr);
            chk("tbl exec rf addrs", {WAddr, RAAddr, RBAddr},
                {vt[i].waddr, vt[i].raaddr, vt[i].rbaddr});
            step();
        end
        chk("tbl end fetch", State, 1);

        // LOAD_A detail, then reset in LOAD_A abandons the write
        fill_rom(16'h5000);
        rom[0] = 16'h2A53;
        reset_dut();
        step();
        step();
        step();
        chk("load_a state", State, 3);
        chk("load_a d_addr", D_Addr, 8'hA5);
        chk("load_a rf_s/wen", {RF_s, Wen}, 2'b10);
        w0 = wen_cnt;
        Rst = 1'b1;
        step();
        Rst = 1'b0;
        chk("rst in load_a state", State, 0);
        chk("rst in load_a pc", PCAddr, 0);
        step();
        chk("rst in load_a no wen", wen_cnt - w0, 0);

        // Full LOAD writes memory data to R3
        dm_init[8'hA5] = 16'hBEEF;
        reset_dut();
        n = 0;
        while (!Halted && n < 100) begin step(); n++; end
        chk("load result r3", rf[3], 16'hBEEF);
        chk("load cycles", n, 1 + 4 + 2);

        // STORE strobes exactly once and never writes the RF
        fill_rom(16'h5000);
        rom[0] = 16'h17C0;
        rf_init[7] = 16'h7777;
        reset_dut();
        w0 = wen_cnt;
        d0 = dwr_cnt;
        n = 0;
        while (!Halted && n < 100) begin step(); n++; end
        chk("store dwr pulses", dwr_cnt - d0, 1);
        chk("store wen pulses", wen_cnt - w0, 0);
        chk("store dmem", dm[8'hC0], 16'h7777);

        // HALT holds until reset
        fill_rom(16'h5000);
        reset_dut();
        step();
        step();
        step();
        chk("halt state", State, 8);
        chk("halt flag", Halted, 1);
        repeat (25) step();
        chk("halt held state", {State, Halted}, {4'd8, 1'b1});
        chk("halt pc frozen", PCAddr, 1);
        Rst = 1'b1;
        step();
        Rst = 1'b0;
        chk("halt reset state", State, 0);
        chk("halt reset pc", PCAddr, 0);
        chk("halt reset flag", Halted, 0);

        // PC wrap across 128 NOOPs
        fill_rom(16'h0000);
        reset_dut();
        step();
        repeat (127 * 3) step();
        chk("pc before wrap", PCAddr, 127);
        repeat (3) step();
        chk("pc wrap state", State, 1);
        chk("pc wrap", PCAddr, 0);

        // Opcode 0110
        fill_rom(16'h0000);
        rom[0] = 16'h6005;
        reset_dut();
        step();
        step();
        step();
`ifdef CTRL_JUMP_EN
        chk("jump state", State, 10);
        chk("jump quiet", {Wen, RAen, RBen, D_Wr, RF_s, ALU_s, Halted}, 0);
        step();
        chk("jump fetch state", State, 1);
        chk("jump target pc", PCAddr, 5);
`else
        chk("op6 noop state", State, 9);
        step();
        chk("op6 fetch state", State, 1);
        chk("op6 pc increments", PCAddr, 1);
`endif

        // Random programs against the ISA model
        for (int t = 0; t < 4; t++) begin
            int len;
            int bad;
            len = 30 + $urandom_range(0, 60);
            for (int i = 0; i < 16; i++) rf_init[i] = 16'($urandom());
            for (int j = 0; j < 256; j++) dm_init[j] = 16'($urandom());
            fill_rom(16'h5000);
            for (int k = 0; k < len; k++) begin
                int pick;
                logic [3:0] op;
                pick = $urandom_range(0, 9);
                if (pick <= 4) op = 4'(pick);
                else op = 4'($urandom_range(7, 15));
                r = 16'($urandom());
                rom[k] = {op, r[11:0]};
            end
            model_run(len);
            reset_dut();
            n = 0;
            while (!Halted && n < 2000) begin step(); n++; end
            chk("rand cycles to halt", n, exp_cyc);
            chk("rand halt pc", PCAddr, len + 1);
            for (int i = 0; i < 16; i++) chk("rand rf", rf[i], m_rf[i]);
            bad = 0;
            for (int j = 0; j < 256; j++) if (dm[j] !== m_dm[j]) bad++;
            chk("rand dmem mismatches", bad, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
